block_combine_stage: RTL and testbench

Single-stage, clocked four-phase (return-to-zero) bundled-data handshake latch: a Muller C-element emulation that combines the upstream request with the inverted downstream acknowledge and captures the data word on the rising phase. It sits between two handshake channels in a micropipeline chain. It accepts a word from the upstream producer, forwards it to the downstream consumer, and acknowledges upstream with the same control bit. The RTL module is named `block_combine_stage`.

---
 rtl/block_combine_stage.sv | 66 ++++++
 tb/tb_block_combine_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/block_combine_stage.sv
// rtl/block_combine_stage.sv - clocked four-phase C-element handshake latch with bundled-data capture
// Optional BLOCK_COMBINE_SYNC_EN adds two-flop synchronizers on req_in and ack_in.
module block_combine_stage #(
  parameter int data_width = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_in,
  input  logic                  ack_in,
  input  logic [data_width-1:0] data_in,
  output logic                  req_out,
  output logic                  ack_out,
  output logic [data_width-1:0] data_out
);

  logic c;
  logic req_eff;
  logic ack_eff;
  logic set_c;
  logic clr_c;

`ifdef BLOCK_COMBINE_SYNC_EN
  logic [1:0] req_sync;
  logic [1:0] ack_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync <= 2'b00;
      ack_sync <= 2'b00;
    end else begin
      req_sync <= {req_sync[0], req_in};
      ack_sync <= {ack_sync[0], ack_in};
    end
  end

  assign req_eff = req_sync[1];
  assign ack_eff = ack_sync[1];
`else
  assign req_eff = req_in;
  assign ack_eff = ack_in;
`endif

  // Mixed or matching levels (1/1, 0/0) fall through to hold, absorbing protocol slips.
  assign set_c = req_eff & ~ack_eff;
  assign clr_c = ~req_eff & ack_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      c        <= 1'b0;
      data_out <= '0;
    end else begin
      if (set_c) begin
        c <= 1'b1;
      end else if (clr_c) begin
        c <= 1'b0;
      end
      if (set_c && !c) begin
        data_out <= data_in;
      end
    end
  end

  assign req_out = c;
  assign ack_out = c;

endmodule

// File: tb/tb_block_combine_stage.sv
// tb/tb_block_combine_stage.sv - directed bench for block_combine_stage
// Each input vector is held for the block's input latency before checking.
module tb_block_combine_stage;

`ifdef BLOCK_COMBINE_SYNC_EN
  localparam int lat = 3;
`else
  localparam int lat = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_in;
  logic       ack_in;
  logic [2:0] data_in;
  logic       req_out;
  logic       ack_out;
  logic [2:0] data_out;

  int checks = 0;
  int errors = 0;

  block_combine_stage #(.data_width(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .ack_in   (ack_in),
    .data_in  (data_in),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [2:0] d);
    req_in  = r;
    ack_in  = a;
    data_in = d;
  endtask

  task automatic apply(input logic r, input logic a, input logic [2:0] d);
    drive(r, a, d);
    repeat (lat) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 3'd7);
    tick();
    check("rst_prio_req_out", req_out, 1'b0);
    check("rst_prio_data_out", data_out, 3'd0);
    drive(1'b0, 1'b0, 3'd0);
    tick();
    check("reset_req_out", req_out, 1'b0);
    check("reset_ack_out", ack_out, 1'b0);
    check("reset_data_out", data_out, 3'd0);
    rst = 1'b0;

`ifdef BLOCK_COMBINE_SYNC_EN
    drive(1'b1, 1'b0, 3'd1);
    tick();
    check("sync_edge1_req_out", req_out, 1'b0);
    tick();
    check("sync_edge2_req_out", req_out, 1'b0);
    tick();
`else
    apply(1'b1, 1'b0, 3'd1);
`endif
    check("w1_req_out", req_out, 1'b1);
    check("w1_ack_out", ack_out, 1'b1);
    check("w1_data_out", data_out, 3'd1);

    apply(1'b1, 1'b1, 3'd2);
    check("hold_req_out", req_out, 1'b1);
    check("hold_data_out", data_out, 3'd1);

    apply(1'b0, 1'b1, 3'd3);
    check("rtz_req_out", req_out, 1'b0);
    check("rtz_ack_out", ack_out, 1'b0);
    check("rtz_data_out", data_out, 3'd1);

    apply(1'b0, 1'b0, 3'd4);
    check("idle_req_out", req_out, 1'b0);
    check("idle_data_out", data_out, 3'd1);

    // Both high while c=0 is a hold, not a capture.
    apply(1'b1, 1'b1, 3'd7);
    check("viol_req_out", req_out, 1'b0);
    check("viol_data_out", data_out, 3'd1);

    apply(1'b1, 1'b0, 3'd5);
    check("w2_req_out", req_out, 1'b1);
    check("w2_data_out", data_out, 3'd5);

    apply(1'b1, 1'b1, 3'd6);
    check("w2_hold_req_out", req_out, 1'b1);
    check("w2_no_capture6", data_out, 3'd5);

    rst = 1'b1;
    tick();
    check("midrst_req_out", req_out, 1'b0);
    check("midrst_ack_out", ack_out, 1'b0);
    check("midrst_data_out", data_out, 3'd0);
    rst = 1'b0;

    apply(1'b1, 1'b1, 3'd6);
    check("post_rst_hold_req", req_out, 1'b0);
    check("post_rst_hold_data", data_out, 3'd0);

    apply(1'b1, 1'b0, 3'd7);
    check("fresh_req_out", req_out, 1'b1);
    check("fresh_data_out", data_out, 3'd7);

    apply(1'b1, 1'b1, 3'd0);
    apply(1'b0, 1'b1, 3'd0);
    check("w3_clear_req_out", req_out, 1'b0);
    check("w3_clear_data_out", data_out, 3'd7);

    // req rise and ack fall together is the set condition.
    apply(1'b1, 1'b0, 3'd2);
    check("simul_req_out", req_out, 1'b1);
    check("simul_data_out", data_out, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
